// File: rtl/parking_gate_fsm.sv
// parking_gate_fsm: two-beam gate sensor front end for the occupancy counter.
// Syncs and debounces the outer (a) and inner (b) beams, tracks a car through
// the gate and emits one tick per complete passage with its direction on sign.
// Optional error reporting (err pulse, err_cnt) is built when PARKING_ERR_EN
// is defined; without it those ports and their logic are absent.
//
// state  | meaning
// IDLE   | both beams clear, nothing in progress
// EN_A   | entry started, outer beam only
// EN_AB  | entry, both beams blocked
// EN_B   | entry, inner beam only (car almost in)
// EX_B   | exit started, inner beam only
// EX_BA  | exit, both beams blocked
// EX_A   | exit, outer beam only (car almost out)
// CLEAR  | illegal sequence seen, wait for both beams clear
module parking_gate_fsm #(
    parameter int   DEBOUNCE = 4,
    parameter logic ACTIVE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    output logic       tick,
    output logic       sign,
`ifdef PARKING_ERR_EN
    output logic       err,
    output logic [7:0] err_cnt,
`endif
    output logic       busy
);

    localparam int             CW     = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]  DB_MAX = CW'(DEBOUNCE);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] EN_A  = 3'd1;
    localparam logic [2:0] EN_AB = 3'd2;
    localparam logic [2:0] EN_B  = 3'd3;
    localparam logic [2:0] EX_B  = 3'd4;
    localparam logic [2:0] EX_BA = 3'd5;
    localparam logic [2:0] EX_A  = 3'd6;
    localparam logic [2:0] CLEAR = 3'd7;

    // Sensors normalised so that 1 always means "beam blocked".
    logic       a_blk;
    logic       b_blk;
    assign a_blk = ~(a ^ ACTIVE);
    assign b_blk = ~(b ^ ACTIVE);

    logic [1:0]    sync1;
    logic [1:0]    y;
    logic [1:0]    y_prev;
    logic [CW-1:0] cnt;
    logic [1:0]    s;
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          pass_entry;
    logic          pass_exit;

    // Two-flop synchronizer on both beams plus one-cycle history for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 2'b00;
            y      <= 2'b00;
            y_prev <= 2'b00;
        end else begin
            sync1  <= {a_blk, b_blk};
            y      <= sync1;
            y_prev <= y;
        end
    end

    // Debounce: any change restarts the count; the vector is accepted once it has
    // been stable long enough, and the counter then parks at DB_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            s   <= 2'b00;
        end else if (y != y_prev) begin
            cnt <= '0;
        end else if (cnt != DB_MAX) begin
            cnt <= cnt + 1'b1;
            if (cnt == DB_MAX - 1'b1) begin
                s <= y;
            end
        end
    end

    // Next-state decode on the debounced vector s = {a, b}; unlisted codes hold.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s == 2'b10)      state_nxt = EN_A;
                else if (s == 2'b01) state_nxt = EX_B;
                else if (s == 2'b11) state_nxt = CLEAR;
            end
            EN_A: begin
                if (s == 2'b11)      state_nxt = EN_AB;
                else if (s == 2'b00) state_nxt = IDLE;
                else if (s == 2'b01) state_nxt = CLEAR;
            end
            EN_AB: begin
                if (s == 2'b01)      state_nxt = EN_B;
                else if (s == 2'b10) state_nxt = EN_A;
                else if (s == 2'b00) state_nxt = CLEAR;
            end
            EN_B: begin
                if (s == 2'b00)      state_nxt = IDLE;
                else if (s == 2'b11) state_nxt = EN_AB;
                else if (s == 2'b10) state_nxt = CLEAR;
            end
            EX_B: begin
                if (s == 2'b11)      state_nxt = EX_BA;
                else if (s == 2'b00) state_nxt = IDLE;
                else if (s == 2'b10) state_nxt = CLEAR;
            end
            EX_BA: begin
                if (s == 2'b10)      state_nxt = EX_A;
                else if (s == 2'b01) state_nxt = EX_B;
                else if (s == 2'b00) state_nxt = CLEAR;
            end
            EX_A: begin
                if (s == 2'b00)      state_nxt = IDLE;
                else if (s == 2'b11) state_nxt = EX_BA;
                else if (s == 2'b01) state_nxt = CLEAR;
            end
            default: begin
                if (s == 2'b00)      state_nxt = IDLE;
            end
        endcase
    end

    assign pass_entry = (state == EN_B) && (s == 2'b00);
    assign pass_exit  = (state == EX_A) && (s == 2'b00);

    // State register and registered tick/sign/busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tick  <= 1'b0;
            sign  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            tick  <= pass_entry | pass_exit;
            busy  <= (state_nxt != IDLE);
            if (pass_entry) begin
                sign <= 1'b1;
            end else if (pass_exit) begin
                sign <= 1'b0;
            end
        end
    end

`ifdef PARKING_ERR_EN
    // Error pulse on each entry into CLEAR and a saturating count of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            err <= (state_nxt == CLEAR) && (state != CLEAR);
            if ((state_nxt == CLEAR) && (state != CLEAR) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_parking_gate_fsm.sv
// Directed bench for parking_gate_fsm (DEBOUNCE=4, ACTIVE=1): a table of
// sensor steps with expected busy/tick-total/sign, plus hand sequences for
// tick latency, glitch filtering and reset in the middle of a passage.
module tb_parking_gate_fsm;

    logic clk = 1'b0;
    logic rst;
    logic a;
    logic b;
    logic tick;
    logic sign;
    logic busy;
`ifdef PARKING_ERR_EN
    logic       err;
    logic [7:0] err_cnt;
    int         err_seen = 0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int tick_seen = 0;

    parking_gate_fsm #(.DEBOUNCE(4), .ACTIVE(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .tick    (tick),
        .sign    (sign),
`ifdef PARKING_ERR_EN
        .err     (err),
        .err_cnt (err_cnt),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Count tick pulses (and err pulses) between edges.
    always @(negedge clk) begin
        if (tick) tick_seen++;
`ifdef PARKING_ERR_EN
        if (err) err_seen++;
`endif
    end

    typedef struct {
        logic [1:0] ab;
        int         cyc;
        logic       exp_busy;
        int         exp_ticks;
        logic       exp_sign;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive {a,b} at a falling edge and hold for n cycles; returns at a falling edge.
    task automatic hold(input logic [1:0] ab, input int n);
        a = ab[1];
        b = ab[0];
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int first;
        int highs;

        // entry
        vecs[0]  = '{2'b10, 10, 1'b1, 1, 1'b0};
        vecs[0].exp_ticks = 0;
        vecs[1]  = '{2'b11, 10, 1'b1, 0, 1'b0};
        vecs[2]  = '{2'b01, 10, 1'b1, 0, 1'b0};
        vecs[3]  = '{2'b00, 10, 1'b0, 1, 1'b1};
        // exit
        vecs[4]  = '{2'b01, 10, 1'b1, 1, 1'b1};
        vecs[5]  = '{2'b11, 10, 1'b1, 1, 1'b1};
        vecs[6]  = '{2'b10, 10, 1'b1, 1, 1'b1};
        vecs[7]  = '{2'b00, 10, 1'b0, 2, 1'b0};
        // back-out
        vecs[8]  = '{2'b10, 10, 1'b1, 2, 1'b0};
        vecs[9]  = '{2'b11, 10, 1'b1, 2, 1'b0};
        vecs[10] = '{2'b10, 10, 1'b1, 2, 1'b0};
        vecs[11] = '{2'b00, 10, 1'b0, 2, 1'b0};
        // illegal 00->11
        vecs[12] = '{2'b11, 10, 1'b1, 2, 1'b0};
        vecs[13] = '{2'b00, 10, 1'b0, 2, 1'b0};
        // illegal in EN_A (10->01)
        vecs[14] = '{2'b10, 10, 1'b1, 2, 1'b0};
        vecs[15] = '{2'b01, 10, 1'b1, 2, 1'b0};
        vecs[16] = '{2'b11, 10, 1'b1, 2, 1'b0};
        vecs[17] = '{2'b00, 10, 1'b0, 2, 1'b0};

        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tick", int'(tick), 0);
        chk("reset_sign", int'(sign), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 18; i++) begin
            hold(vecs[i].ab, vecs[i].cyc);
            chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
            chk($sformatf("v%0d_ticks", i), tick_seen, vecs[i].exp_ticks);
            chk($sformatf("v%0d_sign", i), int'(sign), int'(vecs[i].exp_sign));
        end

        // Latency: release to tick is 2 + 4 + 1 + 1 = 8 cycles, one cycle wide.
        hold(2'b10, 10);
        hold(2'b11, 10);
        hold(2'b01, 10);
        a = 1'b0;
        b = 1'b0;
        first = -1;
        highs = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (tick) begin
                highs++;
                if (first < 0) first = i;
            end
        end
        chk("lat_cycles", first, 8);
        chk("lat_width", highs, 1);
        chk("lat_sign", int'(sign), 1);
        chk("lat_ticks", tick_seen, 3);
        @(negedge clk);

        // 3-cycle drop of a in EN_AB is filtered; completed entry still ticks once.
        hold(2'b10, 10);
        hold(2'b11, 10);
        hold(2'b01, 3);
        hold(2'b11, 10);
        chk("g3a_busy", int'(busy), 1);
        chk("g3a_ticks", tick_seen, 3);
        hold(2'b01, 10);
        hold(2'b00, 10);
        chk("g3a_done_ticks", tick_seen, 4);
        chk("g3a_done_busy", int'(busy), 0);

        // Same filtered glitch, then straight to 00: still EN_AB, so CLEAR, no tick.
        hold(2'b10, 10);
        hold(2'b11, 10);
        hold(2'b01, 3);
        hold(2'b00, 12);
        chk("g3b_ticks", tick_seen, 4);
        chk("g3b_busy", int'(busy), 0);

        // 5-cycle drop is accepted (EN_B), so going to 00 completes the entry.
        hold(2'b10, 10);
        hold(2'b11, 10);
        hold(2'b01, 5);
        hold(2'b00, 12);
        chk("g5_ticks", tick_seen, 5);
        chk("g5_sign", int'(sign), 1);
        chk("g5_busy", int'(busy), 0);

`ifdef PARKING_ERR_EN
        chk("err_cnt", int'(err_cnt), 3);
        chk("err_pulses", err_seen, 3);
`endif

        // Reset while in EN_B aborts the passage.
        hold(2'b10, 10);
        hold(2'b11, 10);
        hold(2'b01, 10);
        chk("enb_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_tick", int'(tick), 0);
        chk("rst_async_sign", int'(sign), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(2'b01, 10);
        hold(2'b00, 15);
        chk("rst_ticks", tick_seen, 5);
        chk("rst_busy", int'(busy), 0);
`ifdef PARKING_ERR_EN
        chk("rst_err_cnt", int'(err_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
